// File: rtl/dma_line_engine.sv
// dma_line_engine: moves whole cache lines between a host FIFO pair and a word-wide memory,
// splitting each line into FILL_COUNT word accesses at consecutive byte addresses.
module dma_line_engine #(
   parameter int CL_SIZE_WIDTH = 512,
   parameter int WORD_SIZE     = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int LEN_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     dir,
   input  logic [ADDR_WIDTH-1:0]    base_addr,
   input  logic [LEN_WIDTH-1:0]     num_lines,
   input  logic                     abort,
   input  logic                     rd_empty,
   input  logic [CL_SIZE_WIDTH-1:0] rd_data,
   output logic                     rd_en,
   input  logic                     wr_full,
   output logic [CL_SIZE_WIDTH-1:0] wr_data,
   output logic                     wr_en,
   output logic                     mem_en,
   output logic                     mem_wr,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [WORD_SIZE-1:0]     mem_wdata,
   input  logic [WORD_SIZE-1:0]     mem_rdata,
   output logic                     busy,
   output logic                     done
);
   localparam int FC = CL_SIZE_WIDTH / WORD_SIZE;
   localparam int IW = $clog2(FC);
   localparam int CW = IW + 2;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_SIZE / 8);

   typedef enum logic [2:0] {IDLE, WAIT_LINE, DRAIN, FILL, PUSH, DONE} state_t;

   state_t                        state_q, state_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d, mem_addr_q, mem_addr_d;
   logic [LEN_WIDTH-1:0]          lines_q, lines_d, num_q, num_d;
   logic                          dir_q, dir_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [FC-1:0][WORD_SIZE-1:0]  buf_q, buf_d;
   logic [WORD_SIZE-1:0]          mem_wdata_q, mem_wdata_d;
   logic                          rd_en_q, rd_en_d, wr_en_q, wr_en_d, mem_en_q, mem_en_d;
   logic                          mem_wr_q, mem_wr_d, busy_q, busy_d, done_q, done_d;
   logic                          line_end;
   logic [IW-1:0]                 slot;

   // read data for the request issued two FILL cycles ago lands in this slot
   assign slot = IW'(cnt_q - CW'(2));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      lines_d     = lines_q;
      num_d       = num_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      line_end    = 1'b0;
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               addr_d  = base_addr;
               num_d   = num_lines;
               dir_d   = dir;
               lines_d = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = num_lines == '0 ? DONE : (dir ? FILL : WAIT_LINE);
            end
            WAIT_LINE: if (!rd_empty) begin
               buf_d   = rd_data;
               rd_en_d = 1'b1;
               cnt_d   = '0;
               state_d = DRAIN;
            end
            DRAIN: begin
               mem_en_d    = 1'b1;
               mem_wr_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = buf_q[cnt_q[IW-1:0]];
               addr_d      = addr_q + STEP;
               cnt_d       = cnt_q + CW'(1);
               line_end    = cnt_q == CW'(FC - 1);
            end
            FILL: begin
               if (cnt_q < CW'(FC)) begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = addr_q;
                  addr_d     = addr_q + STEP;
               end
               if (cnt_q >= CW'(2)) buf_d[slot] = mem_rdata;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(FC + 1)) state_d = PUSH;
            end
            PUSH: if (!wr_full) begin
               wr_en_d  = 1'b1;
               line_end = 1'b1;
            end
            DONE: begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (line_end) begin
            lines_d = lines_q + LEN_WIDTH'(1);
            cnt_d   = '0;
            state_d = lines_d == num_q ? DONE : (dir_q ? FILL : WAIT_LINE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         lines_q     <= '0;
         num_q       <= '0;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         buf_q       <= '0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         lines_q     <= lines_d;
         num_q       <= num_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign wr_en     = wr_en_q;
   assign wr_data   = buf_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: doc/dma_line_engine.md
DMA_LINE_ENGINE -- requirements
Module: dma_line_engine

Interface
REQ-001 SHALL have parameter CL_SIZE_WIDTH, default 512, meaning host cache-line width in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 32, meaning memory word width in bits; CL_SIZE_WIDTH is an integer multiple of it, and FILL_COUNT = CL_SIZE_WIDTH/WORD_SIZE is at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning memory byte-address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, meaning width of the line-count field.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-008 SHALL have port dir, input, 1 bit: direction; 0 = host-to-mem (H2M), 1 = mem-to-host (M2H).
REQ-009 SHALL have port base_addr, input, ADDR_WIDTH bits: first memory byte address.
REQ-010 SHALL have port num_lines, input, LEN_WIDTH bits: number of cache lines to move.
REQ-011 SHALL have port abort, input, 1 bit: cancels the active transfer.
REQ-012 SHALL have port rd_empty, input, 1 bit, and port rd_data, input, CL_SIZE_WIDTH bits: show-ahead host read FIFO; rd_data is valid while rd_empty=0.
REQ-013 SHALL have port rd_en, output, 1 bit: one-cycle FIFO pop.
REQ-014 SHALL have port wr_full, input, 1 bit; wr_data, output, CL_SIZE_WIDTH bits; and wr_en, output, 1 bit: host write FIFO push.
REQ-015 SHALL have port mem_en, output, 1 bit; mem_wr, output, 1 bit; mem_addr, output, ADDR_WIDTH bits; and mem_wdata, output, WORD_SIZE bits: memory request.
REQ-016 SHALL have port mem_rdata, input, WORD_SIZE bits: read data, valid exactly 1 cycle after a read request.
REQ-017 SHALL have port busy, output, 1 bit, and port done, output, 1 bit: status.

Function
REQ-018 SHALL implement states IDLE, WAIT_LINE, DRAIN, FILL, PUSH, DONE; all outputs are registered.
REQ-019 In IDLE with start=1, SHALL latch base_addr, num_lines and dir, clear the line counter, and set busy=1 next cycle; if num_lines=0 it SHALL go to DONE, else to WAIT_LINE (dir=0) or FILL (dir=1).
REQ-020 SHALL ignore start outside IDLE.
REQ-021 In WAIT_LINE with rd_empty=0, SHALL capture rd_data into the line buffer, pulse rd_en for exactly 1 cycle, and enter DRAIN; with rd_empty=1 it SHALL hold with no outputs active.
REQ-022 In DRAIN, SHALL issue FILL_COUNT consecutive writes, one per cycle (mem_en=1, mem_wr=1), with word i = buffer bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE], word 0 first.
REQ-023 In FILL, SHALL issue FILL_COUNT consecutive reads, one per cycle (mem_en=1, mem_wr=0), and SHALL store the data returned 1 cycle after request k into slot k of the line buffer; one extra capture cycle follows the last request, then the block enters PUSH.
REQ-024 In PUSH, SHALL assert wr_en for exactly 1 cycle with wr_data equal to the assembled line in the first cycle with wr_full=0, and SHALL hold while wr_full=1.
REQ-025 SHALL make the first request address base_addr and SHALL increment the address by WORD_SIZE/8 per request, continuously across lines, wrapping modulo 2^ADDR_WIDTH.
REQ-026 After each line, SHALL increment the line counter; when it equals num_lines the block SHALL go to DONE, else back to WAIT_LINE or FILL.
REQ-027 In DONE, SHALL pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-028 SHALL deassert mem_en, mem_wr, rd_en and wr_en in every cycle not listed above.
REQ-029 On abort=1 in any state other than IDLE, SHALL go to IDLE next cycle with busy=0, done=0 and no further requests; a read in flight is discarded. If abort and a handshake (rd_empty=0 in WAIT_LINE, wr_full=0 in PUSH) occur in the same cycle, abort wins and no rd_en or wr_en is issued.

Reset
REQ-030 When rst_n=0 at a clock edge, SHALL force state IDLE, clear the counters and line buffer, and drive all outputs to 0, including mid-transfer.

Verification
REQ-031 H2M, base 0x5000, num_lines=1, rd_data word i = i+1 -> 16 writes to 0x5000..0x503C with data 1..16, one rd_en pulse, done 1 cycle after the last write.
REQ-032 M2H, base 0x100, num_lines=2, mem_rdata = requested address, wr_full=1 for 5 cycles at the second PUSH -> first line words 0x100..0x13C, second push delayed exactly 5 cycles with words 0x140..0x17C, then a single done pulse.
REQ-033 num_lines=0 -> done 2 cycles after start, mem_en never asserted.
REQ-034 abort during H2M DRAIN after word 7 -> mem_en=0 from the next cycle, done never pulses, busy=0, and the following start is accepted.
REQ-035 base 0xFFFFFFF8, H2M, num_lines=1 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ..., 0x34.
REQ-036 start pulsed while busy, then rst_n=0 mid-FILL -> the second start has no effect; after reset all outputs are 0 and the state is IDLE.
